// File: rtl/sysdef_pkg.sv
// Shared system definitions: job types, first-round FIFO geometry and entry layout.
package sysdef_pkg;

    typedef enum logic [1:0] {
        ENCRYPT = 2'd0,
        DECRYPT = 2'd1,
        INVALID = 2'd2
    } job_t;

    localparam int FIFO_DEPTH = 2;
    localparam int TAG_W      = 4;

    typedef struct packed {
        logic [127:0]     data;
        job_t             job;
        logic [TAG_W-1:0] tag;
    } fifo_entry_t;

endpackage

// File: rtl/aes_first_round_if.sv
// Job handshake between the upstream source, the first-round block and the round pipeline.
interface aes_first_round_if;
    import sysdef_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_state;
    job_t             in_type;
    logic [127:0]     key;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out;
    job_t             out_type;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_state, in_type, key, out_ready,
        input  in_ready, out_valid, out, out_type, out_tag
    );

    modport slave (
        input  in_valid, in_state, in_type, key, out_ready,
        output in_ready, out_valid, out, out_type, out_tag
    );
endinterface

// File: rtl/addRoundKey.sv
// AES AddRoundKey: bitwise XOR of the state with a 128-bit round key.
module addRoundKey (
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);
    assign out = state ^ key;
endmodule

// File: rtl/aes_first_round.sv
// AES initial AddRoundKey stage feeding a 2-entry FIFO into the round pipeline.
// Optional accepted-job counter enabled by AES_FIRST_ROUND_CNT_EN.
module aes_first_round
    import sysdef_pkg::*;
(
    input  logic clk,
    input  logic rst,
    aes_first_round_if.slave bus
`ifdef AES_FIRST_ROUND_CNT_EN
    ,
    output logic [15:0] job_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             ready_reg;
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [127:0]     xored;
    logic             push;
    logic             pop;
    fifo_entry_t      entry_reg [FIFO_DEPTH];
    fifo_entry_t      head;

    addRoundKey u_ark (
        .state (bus.in_state),
        .key   (bus.key),
        .out   (xored)
    );

    // ready_reg already reflects state != FULL, so a FULL-cycle pop never admits a push.
    assign push = bus.in_valid && ready_reg && (bus.in_type != INVALID);
    assign pop  = (state_reg != EMPTY) && bus.out_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY:   if (push) state_next = ONE;
            ONE:     if (push && !pop) state_next = FULL;
                     else if (pop && !push) state_next = EMPTY;
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= EMPTY;
            ready_reg  <= 1'b0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            tag_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != FULL);
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
                tag_reg    <= tag_reg + 1'b1;
            end
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) entry_reg[i] <= '0;
        end else if (push) begin
            entry_reg[wr_ptr_reg] <= '{data: xored, job: bus.in_type, tag: tag_reg};
        end
    end

    assign head          = entry_reg[rd_ptr_reg];
    assign bus.in_ready  = ready_reg;
    assign bus.out_valid = (state_reg != EMPTY);
    assign bus.out       = (state_reg != EMPTY) ? head.data : 128'h0;
    assign bus.out_type  = (state_reg != EMPTY) ? head.job  : INVALID;
    assign bus.out_tag   = (state_reg != EMPTY) ? head.tag  : '0;

`ifdef AES_FIRST_ROUND_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) job_count <= '0;
        else if (push && job_count != 16'hFFFF) job_count <= job_count + 16'd1;
    end
`endif

endmodule

// File: doc/aes_first_round.md
AES_FIRST_ROUND -- requirements
Module: aes_first_round

Interface
REQ-001 The block SHALL have one clock and one reset; clock `clk`, reset `rst`, asynchronous, active-high.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- in_valid  in  1  upstream job present
- in_ready  out  1  block can accept a job this cycle
- in_state  in  128  plaintext (ENCRYPT) or ciphertext (DECRYPT)
- in_type  in  job_t  ENCRYPT / DECRYPT / INVALID
- key  in  128  initial round key: round key 0 for ENCRYPT, round key Nr for DECRYPT; valid with in_valid
- out_valid  out  1  round-pipeline entry holds a job
- out_ready  in  1  round pipeline accepts the job
- out  out  128  in_state XOR key
- out_type  out  job_t  type of the head job
- out_tag  out  4  per-job sequence tag
- job_count  out  16  accepted-job count (only with AES_FIRST_ROUND_CNT_EN)

Function
REQ-003 A job SHALL be accepted when in_valid && in_ready && in_type != INVALID.
REQ-004 in_valid with in_type == INVALID SHALL be consumed and dropped: no push, no tag increment, no count.
REQ-005 On acceptance, in_state XOR key SHALL be pushed into a 2-entry FIFO with in_type and the current tag.
REQ-006 A job SHALL be popped when out_valid && out_ready.
REQ-007 FSM states SHALL be EMPTY, ONE and FULL. Transitions: push-only raises occupancy by one; pop-only lowers it by one; push and pop together hold the state.
REQ-008 in_ready SHALL be (state != FULL) and SHALL depend only on registered state. When FULL, no push is taken, even if a pop occurs in the same cycle.
REQ-009 out_valid SHALL be (state != EMPTY). out, out_type and out_tag SHALL reflect the FIFO head.
REQ-010 Latency SHALL be 1 cycle: a job accepted in cycle N is presented with out_valid=1 in cycle N+1 when the FIFO was EMPTY.
REQ-011 Jobs SHALL leave in acceptance order, with no loss or duplication.
REQ-012 The tag counter SHALL increment by one per accepted job and wrap from 15 to 0.
REQ-013 out, out_type and out_tag SHALL hold stable while out_valid && !out_ready.
REQ-014 When EMPTY, out SHALL be 128'h0 and out_type SHALL be INVALID.

Reset
REQ-015 While rst is asserted, the block SHALL hold: state=EMPTY, in_ready=0, out_valid=0, out=0, out_type=INVALID, out_tag=0, tag counter=0, job_count=0.
REQ-016 Reset mid-operation SHALL discard all buffered jobs immediately.
REQ-017 in_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-018 With macro AES_FIRST_ROUND_CNT_EN defined, job_count SHALL exist. It counts accepted jobs per REQ-003, saturates at 16'hFFFF, and is cleared by reset.
REQ-019 Without AES_FIRST_ROUND_CNT_EN, the job_count port and its counter logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-020 job_t (ENCRYPT, DECRYPT, INVALID) SHALL stay in the shared sysdef package.
REQ-021 A FIFO depth constant (2) and the tag width constant (4) SHALL be added to the sysdef package.
REQ-022 The XOR SHALL reuse the existing addRoundKey sub-module. The FIFO and FSM SHALL be local to the block.

Verification
REQ-023 Encrypt: in_state=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, out_ready=1 -> next cycle out=00102030405060708090a0b0c0d0e0f0, out_type=ENCRYPT, out_tag=0.
REQ-024 Decrypt: in_state=69c4e0d86a7b0430d8cdb78070b4c55a, key=13111d7fe3944a17f307a78b4d2b30c5 -> out=7ad5fda789ef4e272bca100b3d9ff59f, out_type=DECRYPT.
REQ-025 Backpressure: out_ready=0 with 3 back-to-back jobs -> in_ready=0 after 2 accepted; first output held stable; release out_ready -> outputs appear in order with tags 0,1,2.
REQ-026 INVALID input: in_valid=1, in_type=INVALID -> out_valid stays 0, tag unchanged, job_count unchanged.
REQ-027 Wrap: 17 accepted jobs -> tags 0..15 then 0; job_count=17 (with AES_FIRST_ROUND_CNT_EN).
REQ-028 Reset while FULL: assert rst -> out_valid=0 and out_type=INVALID immediately; after release, in_ready=1 and next tag=0.
